// File: rtl/tug_match_ctrl.sv
// -----------------------------------------------------------------------------
// tug_match_ctrl
// Match sequencer for the tug-of-war game. Counts round wins per player,
// freezes the field for a short hold after each round, pulses a playfield
// clear between rounds and declares the match winner at WIN_SCORE.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, clears the whole match
//   Lwin, Rwin   round-win levels from the victory detector
//   field_reset  clear request to playfield lights and victory detector
//   play_en      L/R presses allowed into the playfield
//   lscore       left round-win count
//   rscore       right round-win count
//   lhex, rhex   seven-segment score digits, active-low, gfedcba
//   match_over   a player has reached WIN_SCORE
//   winner       00 none, 10 left, 01 right
//
// Parameters
//   WIN_SCORE    round wins needed for the match, 1..7
//   HOLD_CYCLES  cycles the field stays frozen after a round, >= 1
//   HOLD_W       hold counter width, 2**HOLD_W > HOLD_CYCLES
//
// State table
//   state | meaning
//   CLEAR | one-cycle playfield clear, presses blocked
//   PLAY  | round in progress, wins are sampled
//   HOLD  | round finished, field frozen, wins ignored
//   DONE  | match decided, terminal until reset
// -----------------------------------------------------------------------------
module tug_match_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int HOLD_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Lwin,
    input  logic       Rwin,
    output logic       field_reset,
    output logic       play_en,
    output logic [2:0] lscore,
    output logic [2:0] rscore,
    output logic [6:0] lhex,
    output logic [6:0] rhex,
    output logic       match_over,
    output logic [1:0] winner
);

    // Three-bit encoding leaves spare codes; any of them falls back to CLEAR.
    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;

    localparam logic [2:0]        WIN       = 3'(WIN_SCORE);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [2:0]        lscore_q;
    logic [2:0]        lscore_d;
    logic [2:0]        rscore_q;
    logic [2:0]        rscore_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              hold_last;
    logic              score_reached;

    assign hold_last     = (hold_cnt_q == HOLD_LAST);
    assign score_reached = (lscore_q == WIN) || (rscore_q == WIN);

    // Next state and score update.
    always_comb begin
        state_d  = state_q;
        lscore_d = lscore_q;
        rscore_d = rscore_q;
        case (state_q)
            ST_CLEAR: state_d = ST_PLAY;
            ST_PLAY: begin
                // A tie still ends the round; nobody scores and it is replayed.
                if (Lwin || Rwin) begin
                    state_d = ST_HOLD;
                    if (Lwin && !Rwin) begin
                        lscore_d = lscore_q + 3'd1;
                    end else if (Rwin && !Lwin) begin
                        rscore_d = rscore_q + 3'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_last) begin
                    state_d = score_reached ? ST_DONE : ST_CLEAR;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Counter is held at zero outside HOLD, so entering HOLD starts it from 0.
    always_comb begin
        hold_cnt_d = '0;
        if (state_q == ST_HOLD) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            lscore_q   <= 3'd0;
            rscore_q   <= 3'd0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lscore_q   <= lscore_d;
            rscore_q   <= rscore_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [2:0] val);
        logic [6:0] seg;
        case (val)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
        return seg;
    endfunction

    // Outputs decode registered state only; Lwin/Rwin never reach them directly.
    always_comb begin
        field_reset = 1'b0;
        play_en     = 1'b0;
        match_over  = 1'b0;
        winner      = 2'b00;
        case (state_q)
            ST_CLEAR: field_reset = 1'b1;
            ST_PLAY:  play_en     = 1'b1;
            ST_HOLD:  ;
            ST_DONE: begin
                match_over = 1'b1;
                winner     = (lscore_q == WIN) ? 2'b10 : 2'b01;
            end
            default:  field_reset = 1'b1;
        endcase
    end

    assign lscore = lscore_q;
    assign rscore = rscore_q;
    assign lhex   = seg7(lscore_q);
    assign rhex   = seg7(rscore_q);

endmodule

// File: tb/tb_tug_match_ctrl.sv
module tb_tug_match_ctrl;

    localparam int WIN  = 3;
    localparam int HOLD = 4;
    localparam longint NEVER = 64'sh3fff_ffff_ffff_ffff;

    logic       clk;
    logic       reset;
    logic       Lwin;
    logic       Rwin;
    logic       field_reset;
    logic       play_en;
    logic [2:0] lscore;
    logic [2:0] rscore;
    logic [6:0] lhex;
    logic [6:0] rhex;
    logic       match_over;
    logic [1:0] winner;

    tug_match_ctrl #(
        .WIN_SCORE  (WIN),
        .HOLD_CYCLES(HOLD),
        .HOLD_W     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Lwin       (Lwin),
        .Rwin       (Rwin),
        .field_reset(field_reset),
        .play_en    (play_en),
        .lscore     (lscore),
        .rscore     (rscore),
        .lhex       (lhex),
        .rhex       (rhex),
        .match_over (match_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       field_reset;
        logic       play_en;
        logic [2:0] lscore;
        logic [2:0] rscore;
        logic [6:0] lhex;
        logic [6:0] rhex;
        logic       match_over;
        logic [1:0] winner;
    } exp_t;

    exp_t   sb_q[$];
    longint sb_edge_q[$];
    int     n_vec  = 0;
    int     n_fail = 0;

    // Reference model: a timeline of the edges at which each output phase
    // begins, rather than a state machine.
    longint edge_n     = 0;
    longint clear_edge = -1;
    longint play_from  = NEVER;
    longint done_from  = NEVER;
    int     m_l        = 0;
    int     m_r        = 0;

    logic [6:0] seg_lut [8];
    initial begin
        seg_lut[0] = 7'b1000000; seg_lut[1] = 7'b1111001;
        seg_lut[2] = 7'b0100100; seg_lut[3] = 7'b0110000;
        seg_lut[4] = 7'b0011001; seg_lut[5] = 7'b0010010;
        seg_lut[6] = 7'b0000010; seg_lut[7] = 7'b1111000;
    end

    task automatic model_edge(input logic rst_i, input logic l_i, input logic r_i);
        exp_t e;
        if (rst_i) begin
            m_l        = 0;
            m_r        = 0;
            clear_edge = edge_n;
            play_from  = edge_n + 1;
            done_from  = NEVER;
        end else if (edge_n - 1 >= play_from && (l_i || r_i)) begin
            if (l_i && !r_i) m_l++;
            if (r_i && !l_i) m_r++;
            if (m_l == WIN || m_r == WIN) begin
                done_from  = edge_n + HOLD;
                play_from  = NEVER;
            end else begin
                clear_edge = edge_n + HOLD;
                play_from  = edge_n + HOLD + 1;
            end
        end
        e.field_reset = (edge_n == clear_edge);
        e.play_en     = (edge_n >= play_from);
        e.lscore      = 3'(m_l);
        e.rscore      = 3'(m_r);
        e.lhex        = seg_lut[m_l];
        e.rhex        = seg_lut[m_r];
        e.match_over  = (edge_n >= done_from);
        e.winner      = !e.match_over ? 2'b00 : (m_l == WIN ? 2'b10 : 2'b01);
        sb_q.push_back(e);
        sb_edge_q.push_back(edge_n);
        edge_n++;
    endtask

    task automatic step(input logic rst_i, input logic l_i, input logic r_i);
        reset = rst_i;
        Lwin  = l_i;
        Rwin  = r_i;
        @(posedge clk);
        model_edge(rst_i, l_i, r_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input longint at, input logic [7:0] got,
                         input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%b exp=%b", name, at, got, exp);
        end
    endtask

    // Monitor: every cycle is an output presentation for this block.
    initial begin
        exp_t   e;
        longint at;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                at = sb_edge_q.pop_front();
                check("field_reset", at, 8'(field_reset), 8'(e.field_reset));
                check("play_en",     at, 8'(play_en),     8'(e.play_en));
                check("lscore",      at, 8'(lscore),      8'(e.lscore));
                check("rscore",      at, 8'(rscore),      8'(e.rscore));
                check("lhex",        at, 8'(lhex),        8'(e.lhex));
                check("rhex",        at, 8'(rhex),        8'(e.rhex));
                check("match_over",  at, 8'(match_over),  8'(e.match_over));
                check("winner",      at, 8'(winner),      8'(e.winner));
            end
        end
    end

    initial begin
        int wait_cyc;
        reset = 1'b1;
        Lwin  = 1'b0;
        Rwin  = 1'b0;

        // Reset then release: one clear cycle, then play.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        // Single left pulse.
        step(1'b0, 1'b1, 1'b0);
        idle(8);
        // Right level held for six cycles counts once.
        repeat (6) step(1'b0, 1'b0, 1'b1);
        idle(4);
        // Tie: no score, round replayed.
        step(1'b0, 1'b1, 1'b1);
        idle(8);
        // Two more left wins take the match.
        step(1'b0, 1'b1, 1'b0);
        idle(8);
        step(1'b0, 1'b1, 1'b0);
        idle(8);
        // Wins in DONE are ignored.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        idle(3);
        // Reset from DONE.
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        // Reset mid-HOLD.
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b1, 1'b0);
        idle(4);

        // Randomised phase, including persistent win levels and sporadic resets.
        for (int i = 0; i < 600; i++) begin
            logic rr;
            logic ll;
            logic rw;
            int   len;
            rr  = ($urandom_range(0, 59) == 0);
            ll  = ($urandom_range(0, 3) == 0);
            rw  = ($urandom_range(0, 3) == 0);
            len = rr ? $urandom_range(1, 2) : $urandom_range(1, 5);
            for (int j = 0; j < len; j++) step(rr, ll, rw);
        end
        idle(2);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        n_vec++;
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/tug_match_ctrl.md
Name: tug_match_ctrl

Overview:
Match sequencer for the tug-of-war game. It sits above the playfield lights and the victory detector. It counts round wins per player, holds the field frozen after each round, and pulses a playfield clear between rounds. It drives two score hex digits and declares the match winner when a player reaches WIN_SCORE.

Parameters:
WIN_SCORE, 7, round wins needed to take the match; legal range 1..7 (3-bit score).
HOLD_CYCLES, 4, cycles the field stays frozen after a round ends; must be >= 1.
HOLD_W, 8, width of the hold counter; must satisfy 2**HOLD_W > HOLD_CYCLES.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset; clears the whole match
Lwin  input  1  round-win pulse for left player, from victory detector; may stay high several cycles
Rwin  input  1  round-win pulse for right player, from victory detector; may stay high several cycles
field_reset  output  1  playfield/victory clear request to lights and victory detector
play_en  output  1  high when L/R presses are allowed into the playfield
lscore  output  3  left round-win count
rscore  output  3  right round-win count
lhex  output  7  left score on seven-segment, active-low, bit order gfedcba
rhex  output  7  right score on seven-segment, active-low, bit order gfedcba
match_over  output  1  high once a player reaches WIN_SCORE
winner  output  2  match winner: 00 none, 10 left, 01 right

Behaviour:
- All outputs are registered, or decoded from registered state only. No combinational path from Lwin/Rwin to any output.
- Reset (reset=1 at an edge) loads state CLEAR, scores 0 and hold counter 0.
- Output values while in reset or CLEAR: field_reset=1, play_en=0, lscore=rscore=0 (after reset), lhex=rhex=7'b1000000, match_over=0, winner=00.
- Reset dominates every state, including mid-HOLD and DONE.
- CLEAR: field_reset=1, play_en=0. Lasts exactly 1 cycle, then PLAY.
- PLAY: field_reset=0, play_en=1. Evaluated on each edge:
  - Lwin=1, Rwin=0: lscore+1, go to HOLD.
  - Rwin=1, Lwin=0: rscore+1, go to HOLD.
  - Lwin=1, Rwin=1: tie. No score change, go to HOLD; the round is replayed.
  - Neither: stay in PLAY.
- Latency: a win sampled at edge k gives the new score and play_en=0 from edge k onward, i.e. visible in cycle k+1.
- HOLD: play_en=0, field_reset=0. Lwin/Rwin are ignored, so a win level that persists is never double-counted.
  - The counter loads 0 on entry and increments each cycle.
  - After HOLD_CYCLES cycles in HOLD, go to DONE if lscore==WIN_SCORE or rscore==WIN_SCORE, else go to CLEAR.
- Full round timing: win at edge k → HOLD for cycles k+1..k+HOLD_CYCLES → CLEAR at cycle k+HOLD_CYCLES+1 → PLAY at cycle k+HOLD_CYCLES+2.
- DONE: play_en=0, field_reset=0, match_over=1. winner=10 if lscore==WIN_SCORE, else 01.
  - Scores are frozen; wins are ignored.
  - Terminal until reset.
- Scores never exceed WIN_SCORE; the DONE transition guarantees this.
- Score display is a combinational decode of the registered score, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
- Any unreachable state encoding recovers to CLEAR on the next edge.

Test Plan (WIN_SCORE=3, HOLD_CYCLES=4):
- Reset 2 cycles, then release → field_reset=1 and play_en=0 for exactly one cycle, then play_en=1; lhex=rhex=1000000, winner=00.
- In PLAY, Lwin=1 for 1 cycle at edge k → lscore=1 and lhex=1111001 at k+1; play_en=0 during cycles k+1..k+4; field_reset=1 at k+5 only; play_en=1 at k+6.
- Rwin held high for 6 cycles → rscore increments exactly once to 1; field_reset pulses once; play_en returns to 1.
- Lwin=Rwin=1 in the same cycle → both scores unchanged; HOLD then CLEAR occur as for a normal round.
- Three left wins, with one right win interleaved → after the third HOLD: match_over=1, winner=10, lscore=3, rscore=1, play_en=0, no further field_reset; later Lwin/Rwin pulses change nothing.
- Reset asserted mid-HOLD (cycle 2) and in DONE → the next cycle shows scores 0, match_over=0, winner=00, field_reset=1.
